// File: rtl/uart_word_tx.sv
// uart_word_tx: sends one address/data word as a 10-byte 8N1 frame
// (0xaa, addr LSB-first, data LSB-first, 0x55) on uart_txd.
// All outputs come straight from flops; the next-state logic computes
// both the control state and the value the line will carry next cycle.
module uart_word_tx #(
    parameter int CLK_HZ        = 50000000,
    parameter int SCLK_HZ       = 25000000,
    parameter int COUNTER_WIDTH = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        uart_txd
);

    localparam int BIT_CYCLES = CLK_HZ / SCLK_HZ;
    localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(BIT_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = COUNTER_WIDTH'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Byte n of the frame sits in bits [8n+7:8n], so byte 0 (0xaa) goes first.
    function automatic logic [79:0] pack_frame(input logic [31:0] a, input logic [31:0] d);
        return {8'h55, d, a, 8'haa};
    endfunction

    // Bit position byte*8+bit is exactly the concatenation {byte, bit}.
    function automatic logic frame_bit(input logic [79:0] f, input logic [3:0] byte_i,
                                       input logic [2:0] bit_i);
        return f[{byte_i, bit_i}];
    endfunction

    state_t                   state_r, state_s;
    logic [COUNTER_WIDTH-1:0] cnt_r, cnt_s;
    logic [2:0]               bit_idx_r, bit_idx_s;
    logic [3:0]               byte_idx_r, byte_idx_s;
    logic [79:0]              frame_r, frame_s;
    logic                     txd_r, txd_s;
    logic                     ready_r, ready_s;
    logic                     busy_r;
    logic                     done_r, done_s;
    logic                     cnt_last_s;
    logic [2:0]               next_bit_idx_s;

    assign cnt_last_s     = (cnt_r == LAST_CNT);
    assign next_bit_idx_s = bit_idx_r + 3'd1;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_idx_s  = bit_idx_r;
        byte_idx_s = byte_idx_r;
        frame_s    = frame_r;
        txd_s      = txd_r;
        ready_s    = ready_r;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && ready_r) begin
                    state_s    = ST_START;
                    cnt_s      = CNT_ZERO;
                    bit_idx_s  = 3'd0;
                    byte_idx_s = 4'd0;
                    frame_s    = pack_frame(addr, data);
                    ready_s    = 1'b0;
                    txd_s      = 1'b0;
                end else begin
                    ready_s = 1'b1;
                    txd_s   = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_last_s) begin
                    cnt_s     = CNT_ZERO;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                    txd_s     = frame_bit(frame_r, byte_idx_r, 3'd0);
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_last_s) begin
                    cnt_s = CNT_ZERO;
                    if (bit_idx_r == 3'd7) begin
                        state_s   = ST_STOP;
                        bit_idx_s = 3'd0;
                        txd_s     = 1'b1;
                    end else begin
                        bit_idx_s = next_bit_idx_s;
                        txd_s     = frame_bit(frame_r, byte_idx_r, next_bit_idx_s);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_last_s) begin
                    cnt_s = CNT_ZERO;
                    if (byte_idx_r == 4'd9) begin
                        // Last stop bit done: back to idle with a one-cycle done.
                        state_s    = ST_IDLE;
                        byte_idx_s = 4'd0;
                        ready_s    = 1'b1;
                        done_s     = 1'b1;
                        txd_s      = 1'b1;
                    end else begin
                        // Next start bit follows immediately, no idle gap.
                        state_s    = ST_START;
                        byte_idx_s = byte_idx_r + 4'd1;
                        txd_s      = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                cnt_s      = CNT_ZERO;
                bit_idx_s  = 3'd0;
                byte_idx_s = 4'd0;
                ready_s    = 1'b1;
                txd_s      = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 4'd0;
            frame_r    <= 80'h0;
            txd_r      <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_idx_r  <= bit_idx_s;
            byte_idx_r <= byte_idx_s;
            frame_r    <= frame_s;
            txd_r      <= txd_s;
            ready_r    <= ready_s;
            busy_r     <= ~ready_s;
            done_r     <= done_s;
        end
    end

    assign uart_txd = txd_r;
    assign ready    = ready_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a UART decoder pops expected bytes from a
// scoreboard queue; scenario tasks check handshake and frame timing.
module tb_uart_word_tx;

    localparam int BIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        done;
    logic        uart_txd;

    int          vectors     = 0;
    int          miscompares = 0;
    int          rx_count    = 0;
    logic        rx_prev     = 1'b1;
    logic [7:0]  sb[$];

    uart_word_tx #(
        .CLK_HZ(50000000),
        .SCLK_HZ(25000000),
        .COUNTER_WIDTH(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .addr(addr),
        .data(data),
        .ready(ready),
        .busy(busy),
        .done(done),
        .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    // UART receiver: samples the second cycle of each bit at negedges;
    // a byte is abandoned if ready rises mid-byte (frame aborted).
    initial begin : uart_rx
        logic [7:0] rx_b;
        logic       rx_abort;
        logic [7:0] rx_exp;
        forever begin
            @(negedge clk);
            if (rx_prev && (uart_txd === 1'b0)) begin
                rx_b     = 8'h00;
                rx_abort = 1'b0;
                for (int k = 1; k <= 9*BIT + BIT/2; k++) begin
                    @(negedge clk);
                    if (ready === 1'b1) begin
                        rx_abort = 1'b1;
                        break;
                    end
                    if (k == BIT/2) begin
                        vectors++;
                        if (uart_txd !== 1'b0) begin
                            miscompares++;
                            $display("FAIL rx_start_bit got %b want 0", uart_txd);
                        end
                    end else if (k == 9*BIT + BIT/2) begin
                        vectors++;
                        if (uart_txd !== 1'b1) begin
                            miscompares++;
                            $display("FAIL rx_stop_bit got %b want 1", uart_txd);
                        end
                    end else if (k > BIT/2 && ((k - BIT/2) % BIT) == 0) begin
                        rx_b[(k - BIT/2)/BIT - 1] = uart_txd;
                    end
                end
                if (!rx_abort) begin
                    rx_count++;
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL rx_byte got %02h want none (unexpected byte)", rx_b);
                    end else begin
                        rx_exp = sb.pop_front();
                        if (rx_b !== rx_exp) begin
                            miscompares++;
                            $display("FAIL rx_byte got %02h want %02h", rx_b, rx_exp);
                        end
                    end
                end
            end
            rx_prev = (uart_txd === 1'b1);
        end
    end

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        sb.push_back(8'haa);
        for (int i = 0; i < 4; i++) sb.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) sb.push_back(d[8*i +: 8]);
        sb.push_back(8'h55);
    endtask

    // Drives one accepted start; returns at the negedge just after acceptance.
    task automatic start_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        data  = d;
        start = 1'b1;
        push_word(a, d);
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (uart_txd !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL accept got txd=%b ready=%b busy=%b want 0 0 1", uart_txd, ready, busy);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        start = 1'b0;
        addr  = 32'h0;
        data  = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (uart_txd !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values got txd=%b ready=%b busy=%b done=%b want 1 1 0 0",
                     uart_txd, ready, busy, done);
        end
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_idle_stable got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_single_word();
        int done_cnt = 0;
        int done_k   = -1;
        start_word(32'h00005000, 32'h00000001);
        for (int k = 1; k <= 230; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (k == 199) begin
                vectors++;
                if (ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_ready_early got %b want 0", ready);
                end
            end
            if (k == 200) begin
                vectors++;
                if (ready !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_ready_end got ready=%b busy=%b want 1 0", ready, busy);
                end
            end
        end
        vectors++;
        if (done_cnt != 1 || done_k != 200) begin
            miscompares++;
            $display("FAIL single_done got count=%0d at=%0d want 1 at 200", done_cnt, done_k);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL single_bytes got %0d missing want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        int done_k   = -1;
        start_word(32'h00004000, 32'h30040003);
        start = 1'b1;
        for (int k = 1; k <= 450; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (k == 200) begin
                vectors++;
                if (done !== 1'b1 || ready !== 1'b1 || uart_txd !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_gap got done=%b ready=%b txd=%b want 1 1 1",
                             done, ready, uart_txd);
                end
                addr = 32'h00004001;
                data = 32'h00000004;
                push_word(32'h00004001, 32'h00000004);
            end
            if (k == 201) begin
                start = 1'b0;
                vectors++;
                if (uart_txd !== 1'b0 || ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_second_start got txd=%b ready=%b want 0 0", uart_txd, ready);
                end
            end
        end
        vectors++;
        if (done_cnt != 2 || done_k != 401) begin
            miscompares++;
            $display("FAIL b2b_done got count=%0d last=%0d want 2 last 401", done_cnt, done_k);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_bytes got %0d missing want 0", sb.size());
        end
    endtask

    task automatic test_busy_ignore();
        int done_cnt = 0;
        int low_after = 0;
        start_word(32'hdeadbeef, 32'h0badf00d);
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (k == 50) begin
                start = 1'b1;
                addr  = 32'h11111111;
                data  = 32'h22222222;
            end
            if (k == 51) start = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (k > 200 && uart_txd !== 1'b1) low_after++;
        end
        vectors++;
        if (done_cnt != 1 || low_after != 0) begin
            miscompares++;
            $display("FAIL busy_ignore got done=%0d low_after=%0d want 1 0", done_cnt, low_after);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL busy_ignore_bytes got %0d missing want 0", sb.size());
        end
    endtask

    task automatic test_reset_with_start();
        int rx0 = rx_count;
        int low = 0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        addr  = 32'h0000abcd;
        data  = 32'h00001234;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        vectors++;
        if (uart_txd !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start got txd=%b ready=%b busy=%b want 1 1 0", uart_txd, ready, busy);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) low++;
        end
        vectors++;
        if (low != 0 || rx_count != rx0) begin
            miscompares++;
            $display("FAIL reset_start_idle got low=%0d bytes=%0d want 0 0", low, rx_count - rx0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int rx0;
        int done_cnt = 0;
        int low = 0;
        start_word(32'h00004000, 32'h30040003);
        rx0 = rx_count - 0;
        for (int k = 1; k <= 73; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (uart_txd !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got txd=%b ready=%b busy=%b done=%b want 1 1 0 0",
                     uart_txd, ready, busy, done);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (uart_txd !== 1'b1) low++;
        end
        vectors++;
        if (done_cnt != 0 || low != 0 || (rx_count - rx0) != 3) begin
            miscompares++;
            $display("FAIL reset_mid_abandon got done=%0d low=%0d bytes=%0d want 0 0 3",
                     done_cnt, low, rx_count - rx0);
        end
        sb.delete();
        start_word(32'h00004001, 32'h00000004);
        done_cnt = 0;
        for (int k = 1; k <= 230; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        vectors++;
        if (done_cnt != 1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_recover got done=%0d missing=%0d want 1 0", done_cnt, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_reset_with_start();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
